// File: rtl/decremento_pkg.sv
// Shared types and default widths for the sequential decrement unit.
package decremento_pkg;

    localparam int unsigned B_W_DEF = 4;
    localparam int unsigned N_W_DEF = 3;

    localparam logic [B_W_DEF-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dec_step.sv
// Combinational single-step decrementer: y = x + all-ones, with carry-out and signed overflow.
module dec_step #(
    parameter int unsigned B_W = 4
) (
    input  logic [B_W-1:0] x,
    output logic [B_W-1:0] y,
    output logic           carry,
    output logic           ovf
);

    logic [B_W:0] sum;

    // Carry-out is 0 only when x is zero, i.e. the step borrowed.
    assign sum   = {1'b0, x} + {1'b0, {B_W{1'b1}}};
    assign y     = sum[B_W-1:0];
    assign carry = sum[B_W];
    assign ovf   = x[B_W-1] & ~sum[B_W-1];

endmodule

// File: rtl/decremento_seq.sv
// Sequential decrement unit: Y = X - (N+1) with sticky borrow/overflow flags.
// Optional DECREMENTO_SAT_EN: unsigned saturation at zero instead of wrap-around.
module decremento_seq
    import decremento_pkg::*;
#(
    parameter int unsigned B_W = B_W_DEF,
    parameter int unsigned N_W = N_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           Fin,
    input  logic [B_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [N_W-1:0] N,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B_W-1:0] Y,
    output logic           Bout,
    output logic           V
);

    state_t         state;
    logic [B_W-1:0] acc;
    logic [N_W-1:0] cnt;
    logic [B_W-1:0] step_y;
    logic           step_c;
    logic           step_v;
    logic [B_W-1:0] next_acc;

    dec_step #(.B_W(B_W)) u_step (
        .x     (acc),
        .y     (step_y),
        .carry (step_c),
        .ovf   (step_v)
    );

`ifdef DECREMENTO_SAT_EN
    assign next_acc = (acc == '0) ? '0 : step_y;
`else
    assign next_acc = step_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            Y         <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= Fin ? B : A;
                        cnt      <= N;
                        Bout     <= 1'b0;
                        V        <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= STEP;
                    end
                end
                STEP: begin
                    acc  <= next_acc;
                    Bout <= Bout | ~step_c;
                    V    <= V | step_v;
                    if (cnt == '0) begin
                        Y         <= next_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - N_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decremento_seq.sv
// Self-checking bench for decremento_seq: directed table, corner sequences, randomized vs. model.
module tb_decremento_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       Fin;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] N;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Y;
    logic       Bout;
    logic       V;

    int checks = 0;
    int errors = 0;

`ifdef DECREMENTO_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    decremento_seq #(.B_W(4), .N_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Fin       (Fin),
        .A         (A),
        .B         (B),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Bout      (Bout),
        .V         (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       fin;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] n;
        logic [3:0] y;
        logic       bout;
        logic       v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: apply N+1 unit decrements with plain integer arithmetic.
    function automatic void model(input logic [3:0] x0, input int n, input bit sat,
                                  output logic [3:0] y, output logic bo, output logic v);
        int x;
        x  = int'(x0);
        bo = 1'b0;
        v  = 1'b0;
        for (int i = 0; i <= n; i++) begin
            if (x == 0) begin
                bo = 1'b1;
                x  = sat ? 0 : 15;
            end else begin
                if (x == 8) v = 1'b1;
                x = x - 1;
            end
        end
        y = 4'(x);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge where out_valid is seen.
    task automatic start_txn(input logic fin, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] n, output int lat);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        Fin = fin; A = a; B = b; N = n;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_busy", 32'(in_ready), 32'd0);
    endtask

    task automatic finish_txn(input int delay);
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [3:0] ey, input logic eb,
                                input logic ev, input int elat, input int lat);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(Y), 32'(ey));
        check({tag, "_bout"}, 32'(Bout), 32'(eb));
        check({tag, "_v"}, 32'(V), 32'(ev));
        check({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    vec_t       vecs[$];
    int         lat;
    logic [3:0] my;
    logic       mb;
    logic       mv;
    logic [3:0] hy;
    logic       hb;
    logic       hv;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Fin = 1'b0; A = '0; B = '0; N = '0;

        vecs.push_back('{1'b0, 4'h5, 4'h0, 3'd0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 4'h2, 3'd3, 4'hE, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 4'h8, 4'h3, 3'd0, 4'h7, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 4'h9, 4'h1, 3'd1, 4'h7, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 4'h3, 4'hF, 3'd7, 4'h7, 1'b0, 1'b1});
`ifdef DECREMENTO_SAT_EN
        vecs.push_back('{1'b0, 4'h1, 4'h7, 3'd2, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 4'h6, 4'h0, 3'd7, 4'h0, 1'b1, 1'b0});
`else
        vecs.push_back('{1'b0, 4'h1, 4'h7, 3'd2, 4'hE, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 4'h6, 4'h0, 3'd7, 4'h8, 1'b1, 1'b0});
`endif

        #1;
        check("rst_y", 32'(Y), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_v", 32'(V), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            start_txn(vecs[i].fin, vecs[i].a, vecs[i].b, vecs[i].n, lat);
            check_result($sformatf("vec%0d", i), vecs[i].y, vecs[i].bout, vecs[i].v,
                         int'(vecs[i].n) + 1, lat);
            finish_txn(0);
        end

        // Hold in DONE with out_ready low while a competing request is presented.
        start_txn(1'b1, 4'h0, 4'h2, 3'd3, lat);
        hy = Y; hb = Bout; hv = V;
        check("hold_first_y", 32'(hy), 32'hE);
        in_valid = 1'b1; Fin = 1'b0; A = 4'h5; N = 3'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", 32'(Y), 32'(hy));
            check("hold_bout", 32'(Bout), 32'(hb));
            check("hold_v", 32'(V), 32'(hv));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // out_ready and in_valid together: release now, new request accepted next cycle.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("both_valid_drop", 32'(out_valid), 32'd0);
        check("both_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("both_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_result("both_new", 4'h4, 1'b0, 1'b0, 1, lat);
        finish_txn(1);

        // Reset in the middle of a STEP sequence.
        start_txn(1'b0, 4'h7, 4'h0, 3'd0, lat);
        finish_txn(0);
        check("pre_rst_y", 32'(Y), 32'h6);
        in_valid = 1'b1; Fin = 1'b1; B = 4'h9; A = 4'h0; N = 3'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", 32'(Y), 32'd0);
        check("mid_rst_bout", 32'(Bout), 32'd0);
        check("mid_rst_v", 32'(V), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
            check("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        start_txn(1'b1, 4'h0, 4'h9, 3'd5, lat);
        check_result("post_rst", 4'h3, 1'b0, 1'b1, 6, lat);
        finish_txn(0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic       rf;
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] rn;
            rf = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rn = 3'($urandom_range(0, 7));
            model(rf ? rb : ra, int'(rn), SAT, my, mb, mv);
            start_txn(rf, ra, rb, rn, lat);
            check_result($sformatf("rnd%0d", t), my, mb, mv, int'(rn) + 1, lat);
            finish_txn(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
